// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory boot loader: geometry defaults,
// FSM state encodings and the accepted program-length range.
package loader_pkg;

   localparam int unsigned LDR_DEPTH   = 32;
   localparam int unsigned LDR_AW      = 5;
   localparam int unsigned LDR_DW      = 8;
   localparam int unsigned LDR_MIN_LEN = 1;
   localparam int unsigned LDR_MAX_LEN = LDR_DEPTH;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LEN  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_CSUM = 3'd3;
   localparam logic [2:0] ST_RUN  = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   // Upper bound is the instantiated memory depth, which defaults to LDR_MAX_LEN.
   function automatic logic len_in_range(input int unsigned n, input int unsigned depth);
      return (n >= LDR_MIN_LEN) && (n <= depth);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a length byte, N program bytes and an XOR checksum from a
// byte stream, writes them to external instruction memory and releases the core.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH = LDR_DEPTH,
   parameter int unsigned AW    = LDR_AW,
   parameter int unsigned DW    = LDR_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          rx_valid,
   input  logic [DW-1:0] rx_data,
   output logic          rx_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_waddr,
   output logic [DW-1:0] imem_wdata,
   output logic          proc_reset,
   output logic          busy,
   output logic          error,
   output logic [AW:0]   load_count
);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] last_q, last_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [DW-1:0] csum_q, csum_d;
   logic          we_d;
   logic [AW-1:0] waddr_d;
   logic [DW-1:0] wdata_d;
   logic [AW:0]   cnt_d;
   logic          in_xfer_state;
   logic          xfer;

   assign xfer = rx_valid & rx_ready;

   // Next-state and datapath updates; nothing moves without a handshake.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      waddr_d = imem_waddr;
      wdata_d = imem_wdata;
      cnt_d   = load_count;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (xfer) begin
               if (len_in_range(32'(rx_data), DEPTH)) begin
                  state_d = ST_DATA;
                  last_d  = AW'(rx_data - DW'(1));
                  idx_d   = '0;
                  csum_d  = '0;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               we_d    = 1'b1;
               waddr_d = idx_q;
               wdata_d = rx_data;
               csum_d  = csum_q ^ rx_data;
               idx_d   = idx_q + AW'(1);
               cnt_d   = load_count + (AW+1)'(1);
               if (idx_q == last_q) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (xfer) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
         end
         ST_RUN, ST_ERR: begin
            if (start) state_d = ST_LEN;
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_d == ST_LEN) && (state_q != ST_LEN)) cnt_d = '0;
   end

   assign in_xfer_state = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);

   // Status outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         last_q     <= '0;
         idx_q      <= '0;
         csum_q     <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         load_count <= '0;
         rx_ready   <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         proc_reset <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         imem_we    <= we_d;
         imem_waddr <= waddr_d;
         imem_wdata <= wdata_d;
         load_count <= cnt_d;
         rx_ready   <= in_xfer_state;
         busy       <= in_xfer_state;
         error      <= (state_d == ST_ERR);
         proc_reset <= (state_d == ST_RUN);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a behavioural instruction
// memory that captures every write strobe.
module tb_imem_loader;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [DW-1:0] imem_wdata;
   logic          proc_reset;
   logic          busy;
   logic          error;
   logic [AW:0]   load_count;

   int compared   = 0;
   int mismatched = 0;

   logic [DW-1:0] mem      [0:DEPTH-1];
   logic [AW-1:0] addr_log [0:511];
   int            wr_count = 0;
   logic [7:0]    dbytes   [0:63];

   imem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .proc_reset (proc_reset),
      .busy       (busy),
      .error      (error),
      .load_count (load_count)
   );

   always #5 clk = ~clk;

   // External memory model; also logs every write address in order.
   always @(posedge clk) begin
      if (imem_we === 1'b1) begin
         mem[imem_waddr] <= imem_wdata;
         if (wr_count < 512) addr_log[wr_count] <= imem_waddr;
         wr_count <= wr_count + 1;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (rx_ready !== 1'b1) begin
         $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
         mismatched++;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h5A;
   endtask

   task automatic load_seq(input int n, input logic [7:0] csum);
      pulse_start();
      send_byte(8'(n));
      for (int i = 0; i < n; i++) send_byte(dbytes[i]);
      send_byte(csum);
   endtask

   task automatic test_reset();
      int base;
      reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      compared++; if (proc_reset !== 1'b0) begin $display("FAIL rst_proc_reset: got %b want 0", proc_reset); mismatched++; end
      compared++; if (imem_we !== 1'b0) begin $display("FAIL rst_imem_we: got %b want 0", imem_we); mismatched++; end
      compared++; if (rx_ready !== 1'b0) begin $display("FAIL rst_rx_ready: got %b want 0", rx_ready); mismatched++; end
      compared++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); mismatched++; end
      compared++; if (error !== 1'b0) begin $display("FAIL rst_error: got %b want 0", error); mismatched++; end
      compared++; if (load_count !== 6'd0) begin $display("FAIL rst_load_count: got %0d want 0", load_count); mismatched++; end
      compared++; if (imem_waddr !== 5'd0) begin $display("FAIL rst_waddr: got %0d want 0", imem_waddr); mismatched++; end
      compared++; if (imem_wdata !== 8'h00) begin $display("FAIL rst_wdata: got %h want 00", imem_wdata); mismatched++; end
      reset = 1'b1;
      base = wr_count;
      // Source presents data while the loader is idle: must be ignored.
      rx_valid = 1'b1; rx_data = 8'h03;
      repeat (3) @(negedge clk);
      compared++; if (rx_ready !== 1'b0) begin $display("FAIL idle_rx_ready: got %b want 0", rx_ready); mismatched++; end
      compared++; if (busy !== 1'b0) begin $display("FAIL idle_busy: got %b want 0", busy); mismatched++; end
      compared++; if (wr_count !== base) begin $display("FAIL idle_no_write: got %0d writes want 0", wr_count - base); mismatched++; end
      rx_valid = 1'b0;
   endtask

   task automatic test_basic_load();
      int base;
      base = wr_count;
      dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33;
      pulse_start();
      compared++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin $display("FAIL basic_len_state: busy=%b rx_ready=%b want 1 1", busy, rx_ready); mismatched++; end
      compared++; if (load_count !== 6'd0) begin $display("FAIL basic_count_clear: got %0d want 0", load_count); mismatched++; end
      send_byte(8'd3);
      compared++; if (imem_we !== 1'b0) begin $display("FAIL basic_len_no_we: got %b want 0", imem_we); mismatched++; end
      for (int i = 0; i < 3; i++) begin
         send_byte(dbytes[i]);
         compared++;
         if (imem_we !== 1'b1 || imem_waddr !== 5'(i) || imem_wdata !== dbytes[i]) begin
            $display("FAIL basic_write%0d: we=%b addr=%0d data=%h want 1 %0d %h", i, imem_we, imem_waddr, imem_wdata, i, dbytes[i]);
            mismatched++;
         end
      end
      compared++; if (proc_reset !== 1'b0) begin $display("FAIL basic_csum_proc_reset: got %b want 0", proc_reset); mismatched++; end
      send_byte(8'h00);
      compared++; if (proc_reset !== 1'b1) begin $display("FAIL basic_run_proc_reset: got %b want 1", proc_reset); mismatched++; end
      compared++; if (busy !== 1'b0 || error !== 1'b0) begin $display("FAIL basic_run_flags: busy=%b error=%b want 0 0", busy, error); mismatched++; end
      compared++; if (load_count !== 6'd3) begin $display("FAIL basic_load_count: got %0d want 3", load_count); mismatched++; end
      compared++; if (wr_count - base !== 3) begin $display("FAIL basic_write_count: got %0d want 3", wr_count - base); mismatched++; end
      compared++;
      if (mem[0] !== 8'h11 || mem[1] !== 8'h22 || mem[2] !== 8'h33) begin
         $display("FAIL basic_mem: got %h %h %h want 11 22 33", mem[0], mem[1], mem[2]);
         mismatched++;
      end
   endtask

   task automatic test_bad_csum();
      dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33;
      load_seq(3, 8'h01);
      compared++; if (error !== 1'b1 || proc_reset !== 1'b0 || busy !== 1'b0) begin $display("FAIL badcsum_err: error=%b proc_reset=%b busy=%b want 1 0 0", error, proc_reset, busy); mismatched++; end
      pulse_start();
      compared++; if (error !== 1'b0 || busy !== 1'b1) begin $display("FAIL badcsum_restart: error=%b busy=%b want 0 1", error, busy); mismatched++; end
      send_byte(8'd3);
      for (int i = 0; i < 3; i++) send_byte(dbytes[i]);
      send_byte(8'h00);
      compared++; if (proc_reset !== 1'b1 || error !== 1'b0) begin $display("FAIL badcsum_recover: proc_reset=%b error=%b want 1 0", proc_reset, error); mismatched++; end
   endtask

   task automatic test_bad_len();
      int base;
      base = wr_count;
      pulse_start();
      send_byte(8'd0);
      compared++; if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin $display("FAIL len0_err: error=%b busy=%b rx_ready=%b want 1 0 0", error, busy, rx_ready); mismatched++; end
      pulse_start();
      send_byte(8'd33);
      compared++; if (error !== 1'b1 || busy !== 1'b0) begin $display("FAIL len33_err: error=%b busy=%b want 1 0", error, busy); mismatched++; end
      compared++; if (wr_count !== base) begin $display("FAIL badlen_no_write: got %0d writes want 0", wr_count - base); mismatched++; end
      compared++; if (load_count !== 6'd0) begin $display("FAIL badlen_count: got %0d want 0", load_count); mismatched++; end
   endtask

   task automatic test_full_depth();
      int base;
      int bad;
      base = wr_count;
      bad  = 0;
      for (int i = 0; i < 32; i++) dbytes[i] = 8'(i);
      load_seq(32, 8'h00);
      compared++; if (wr_count - base !== 32) begin $display("FAIL full_write_count: got %0d want 32", wr_count - base); mismatched++; end
      compared++; if (load_count !== 6'd32) begin $display("FAIL full_load_count: got %0d want 32", load_count); mismatched++; end
      compared++; if (proc_reset !== 1'b1) begin $display("FAIL full_proc_reset: got %b want 1", proc_reset); mismatched++; end
      for (int k = 0; k < 32; k++) if (addr_log[base + k] !== 5'(k)) bad++;
      compared++; if (bad !== 0) begin $display("FAIL full_addr_seq: %0d out-of-order addresses want 0", bad); mismatched++; end
      compared++; if (mem[31] !== 8'h1F || mem[0] !== 8'h00) begin $display("FAIL full_mem: mem31=%h mem0=%h want 1f 00", mem[31], mem[0]); mismatched++; end
   endtask

   task automatic test_valid_toggle();
      int gap;
      dbytes[0] = 8'hA1; dbytes[1] = 8'hB2; dbytes[2] = 8'hC3; dbytes[3] = 8'hD4;
      pulse_start();
      send_byte(8'd4);
      for (int i = 0; i < 4; i++) begin
         gap = int'($urandom_range(1, 3));
         for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
            start    = (i == 1 && g == 0);
            @(negedge clk);
            start = 1'b0;
            compared++;
            if (imem_we !== 1'b0 || busy !== 1'b1) begin
               $display("FAIL toggle_gap%0d: we=%b busy=%b want 0 1", i, imem_we, busy);
               mismatched++;
            end
         end
         send_byte(dbytes[i]);
         compared++;
         if (imem_we !== 1'b1 || imem_waddr !== 5'(i) || imem_wdata !== dbytes[i]) begin
            $display("FAIL toggle_write%0d: we=%b addr=%0d data=%h want 1 %0d %h", i, imem_we, imem_waddr, imem_wdata, i, dbytes[i]);
            mismatched++;
         end
      end
      send_byte(8'h04);
      compared++; if (proc_reset !== 1'b1 || load_count !== 6'd4) begin $display("FAIL toggle_run: proc_reset=%b load_count=%0d want 1 4", proc_reset, load_count); mismatched++; end
      compared++;
      if (mem[0] !== 8'hA1 || mem[1] !== 8'hB2 || mem[2] !== 8'hC3 || mem[3] !== 8'hD4) begin
         $display("FAIL toggle_mem: got %h %h %h %h want a1 b2 c3 d4", mem[0], mem[1], mem[2], mem[3]);
         mismatched++;
      end
   endtask

   task automatic test_reset_midload();
      int base;
      base = wr_count;
      pulse_start();
      send_byte(8'd5);
      send_byte(8'h10);
      send_byte(8'h20);
      reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h30;
      @(negedge clk);
      compared++; if (busy !== 1'b0 || rx_ready !== 1'b0 || proc_reset !== 1'b0 || error !== 1'b0) begin $display("FAIL midrst_flags: busy=%b rx_ready=%b proc_reset=%b error=%b want 0 0 0 0", busy, rx_ready, proc_reset, error); mismatched++; end
      compared++; if (imem_we !== 1'b0 || imem_waddr !== 5'd0 || imem_wdata !== 8'h00 || load_count !== 6'd0) begin $display("FAIL midrst_regs: we=%b addr=%0d data=%h count=%0d want 0 0 00 0", imem_we, imem_waddr, imem_wdata, load_count); mismatched++; end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      compared++; if (wr_count - base !== 2) begin $display("FAIL midrst_writes: got %0d want 2", wr_count - base); mismatched++; end
      compared++; if (mem[0] !== 8'h10 || mem[1] !== 8'h20 || mem[2] !== 8'hC3) begin $display("FAIL midrst_mem: got %h %h %h want 10 20 c3", mem[0], mem[1], mem[2]); mismatched++; end
      dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33;
      load_seq(3, 8'h00);
      compared++; if (proc_reset !== 1'b1) begin $display("FAIL rerun_proc_reset: got %b want 1", proc_reset); mismatched++; end
      pulse_start();
      compared++; if (proc_reset !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1 || load_count !== 6'd0) begin $display("FAIL run_restart: proc_reset=%b busy=%b rx_ready=%b count=%0d want 0 1 1 0", proc_reset, busy, rx_ready, load_count); mismatched++; end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic_load();
      test_bad_csum();
      test_bad_len();
      test_full_depth();
      test_valid_toggle();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
